trainer_stimulus_seq: RTL

Input stage that drives the `a`/`b` operand pair of the digital trainer gate block from board switches and push-buttons. It synchronises and debounces all raw inputs. It then supplies operands in one of three ways: directly from the switches, auto-stepped through the four-row truth table, or single-stepped by button. It sits directly upstream of the trainer gate block; `a` and `b` wire straight to its inputs.

---
 rtl/trainer_pkg.sv | 22 ++
 rtl/trainer_debounce.sv | 52 +++++
 rtl/trainer_stimulus_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/trainer_pkg.sv
// Shared definitions for the trainer stimulus sequencer: mode encoding,
// truth-table geometry and the row-advance helper.
package trainer_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_STEP   = 2'd2
    } trainer_mode_t;

    localparam int unsigned TRAINER_ROWS  = 4;
    localparam int unsigned TRAINER_ROW_W = 2;

    // Advance a truth-table row, wrapping from the last row back to 0.
    function automatic logic [TRAINER_ROW_W-1:0] next_row(input logic [TRAINER_ROW_W-1:0] row);
        if (row == TRAINER_ROW_W'(TRAINER_ROWS - 1)) begin
            return '0;
        end
        return row + TRAINER_ROW_W'(1);
    endfunction

endpackage

// File: rtl/trainer_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw board input.
// level flips after DEBOUNCE_CYCLES consecutive cycles of disagreement;
// rise is a registered one-cycle pulse coincident with a 0->1 level flip.
module trainer_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned            CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    // Count disagreement cycles; flip the level once the run is long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_q == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/trainer_stimulus_seq.sv
// Operand source for the trainer gate block. Debounces the switches and
// buttons, then drives a/b manually, auto-stepped or button-stepped.
// Optional feature macro: TRAINER_SEQ_STEP_EN (STEP mode and btn_step).
module trainer_stimulus_seq
    import trainer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES    = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sw_a,
    input  logic                     sw_b,
    input  logic                     btn_mode,
    input  logic                     btn_step,
    output logic                     a,
    output logic                     b,
    output logic [1:0]               mode,
    output logic [TRAINER_ROW_W-1:0] step_idx,
    output logic                     step_strobe
);

    localparam int unsigned        DWELL_W    = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    localparam logic [1:0] ST_MANUAL = MODE_MANUAL;
    localparam logic [1:0] ST_AUTO   = MODE_AUTO;
    localparam logic [1:0] ST_STEP   = MODE_STEP;

`ifdef TRAINER_SEQ_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic sw_a_lvl;
    logic sw_b_lvl;
    logic mode_press;
    logic step_press;
    logic unused_sw_a_rise;
    logic unused_sw_b_rise;
    logic unused_mode_lvl;

    logic [1:0]               mode_nxt;
    logic [TRAINER_ROW_W-1:0] idx_nxt;
    logic [DWELL_W-1:0]       dwell_q;
    logic [DWELL_W-1:0]       dwell_nxt;
    logic                     a_nxt;
    logic                     b_nxt;
    logic                     strobe_nxt;

    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_a),
        .level (sw_a_lvl),
        .rise  (unused_sw_a_rise)
    );

    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw_b (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_b),
        .level (sw_b_lvl),
        .rise  (unused_sw_b_rise)
    );

    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_mode),
        .level (unused_mode_lvl),
        .rise  (mode_press)
    );

`ifdef TRAINER_SEQ_STEP_EN
    logic unused_step_lvl;

    trainer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_step),
        .level (unused_step_lvl),
        .rise  (step_press)
    );
`else
    logic unused_btn_step;

    assign unused_btn_step = btn_step;
    assign step_press      = 1'b0;
`endif

    // Mode, row and operand state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= ST_MANUAL;
            step_idx    <= '0;
            dwell_q     <= '0;
            a           <= 1'b0;
            b           <= 1'b0;
            step_strobe <= 1'b0;
        end else begin
            mode        <= mode_nxt;
            step_idx    <= idx_nxt;
            dwell_q     <= dwell_nxt;
            a           <= a_nxt;
            b           <= b_nxt;
            step_strobe <= strobe_nxt;
        end
    end

    // Next mode/row/operands; a mode press pre-empts any step that cycle.
    always_comb begin
        mode_nxt   = mode;
        idx_nxt    = step_idx;
        dwell_nxt  = dwell_q;
        a_nxt      = a;
        b_nxt      = b;
        strobe_nxt = 1'b0;

        if (mode_press) begin
            case (mode)
                ST_MANUAL: mode_nxt = ST_AUTO;
                ST_AUTO:   mode_nxt = STEP_EN ? ST_STEP : ST_MANUAL;
                default:   mode_nxt = ST_MANUAL;
            endcase
            idx_nxt   = '0;
            dwell_nxt = '0;
            if (mode_nxt == ST_MANUAL) begin
                a_nxt = sw_a_lvl;
                b_nxt = sw_b_lvl;
            end else begin
                a_nxt = 1'b0;
                b_nxt = 1'b0;
            end
        end else begin
            case (mode)
                ST_MANUAL: begin
                    idx_nxt   = '0;
                    dwell_nxt = '0;
                    a_nxt     = sw_a_lvl;
                    b_nxt     = sw_b_lvl;
                end
                ST_AUTO: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_nxt      = '0;
                        idx_nxt        = next_row(step_idx);
                        {a_nxt, b_nxt} = idx_nxt;
                        strobe_nxt     = 1'b1;
                    end else begin
                        dwell_nxt = dwell_q + DWELL_W'(1);
                    end
                end
                ST_STEP: begin
                    if (step_press) begin
                        idx_nxt        = next_row(step_idx);
                        {a_nxt, b_nxt} = idx_nxt;
                        strobe_nxt     = 1'b1;
                    end
                end
                default: begin
                    mode_nxt  = ST_MANUAL;
                    idx_nxt   = '0;
                    dwell_nxt = '0;
                end
            endcase
        end
    end

endmodule
